fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the pipelined `operation` core and supplies its `inst0`/`pc` inputs. Owns the fetch program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a 2-entry prefetch queue, so stalls from the hazard flags never lose or re-fetch an instruction. Flushes and redirects on a taken branch.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [1:0]  QDEPTH   = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO. Entry 0 is always the head.
// Flush has priority over push and pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t q0_q, q0_d, q1_q, q1_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop & (count_q != 2'd0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push & ((count_q != QDEPTH) | do_pop);

    always_comb begin
        q0_d    = q0_q;
        q1_d    = q1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) q0_d = din;
                    else                 q1_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    q0_d    = q1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        q0_d = din;
                    end else begin
                        q0_d = q1_q;
                        q1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q    <= '0;
            q1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            count_q <= count_d;
        end
    end

    assign head  = q0_q;
    assign count = count_q;
    assign full  = (count_q == QDEPTH);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues req/ack reads and presents the
// prefetch queue head to the core. A taken branch flushes and redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst0,
    output logic [31:0] pc,
    output logic        inst_valid
);

    logic [31:0]  fpc_q, fpc_d;
    logic         pop, push;
    logic         q_full, q_empty;
    logic [1:0]   q_count;
    fetch_entry_t q_head, q_din;
    logic         unused_sigs;

    assign unused_sigs = ^{br_target[1:0], q_count};

    assign inst_valid = !q_empty;
    assign pop        = inst_valid & !stall & !br_taken;
    assign imem_req   = !br_taken & (!q_full | pop);
    assign imem_addr  = fpc_q;
    assign push       = imem_req & imem_ack;
    assign q_din      = '{pc: fpc_q, inst: imem_rdata};

    always_comb begin
        fpc_d = fpc_q;
        if (br_taken) begin
            fpc_d = {br_target[31:2], 2'b00};
        end else if (push) begin
            fpc_d = fpc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q <= RESET_PC;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (br_taken),
        .din   (q_din),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Empty queue presents a bubble tagged with the fetch PC.
    assign inst0 = inst_valid ? q_head.inst : NOP_INST;
    assign pc    = inst_valid ? q_head.pc   : fpc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory model returns the address as data.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ack_all;
    logic [1:0]  tick = 2'd0;
    logic        imem_ack;

    logic        req1, req2;
    logic [31:0] addr1, addr2, inst1, inst2, pc1, pc2;
    logic        valid1, valid2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) tick <= (tick == 2'd2) ? 2'd0 : tick + 2'd1;

    assign imem_ack = ack_all | (tick == 2'd0);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (req1),
        .imem_addr  (addr1),
        .imem_ack   (imem_ack),
        .imem_rdata (addr1),
        .inst0      (inst1),
        .pc         (pc1),
        .inst_valid (valid1)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (req2),
        .imem_addr  (addr2),
        .imem_ack   (imem_ack),
        .imem_rdata (addr2),
        .inst0      (inst2),
        .pc         (pc2),
        .inst_valid (valid2)
    );

    task automatic test_reset;
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; ack_all = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({inst1, pc1, valid1} !== {32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_out: inst0=%h pc=%h valid=%b, want 0/0/0", inst1, pc1, valid1);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req1, addr1} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_req: req=%b addr=%h, want 1/0", req1, addr1);
        end
    endtask

    task automatic test_stream;
        logic [31:0] exp_inst [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        logic        exp_val  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({inst1, pc1, valid1} !== {exp_inst[i], exp_inst[i], exp_val[i]}) begin
                errors++;
                $display("FAIL stream[%0d]: inst0=%h pc=%h valid=%b, want %h/%h/%b",
                         i, inst1, pc1, valid1, exp_inst[i], exp_inst[i], exp_val[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        checks++;
        if (inst1 !== 32'h10) begin
            errors++;
            $display("FAIL stall_pre: inst0=%h, want 10", inst1);
        end
        stall = 1'b1;
        #1;
        checks++;
        if (req1 !== 1'b1) begin
            errors++;
            $display("FAIL stall_req_first: req=%b, want 1", req1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({inst1, pc1, req1} !== {32'h10, 32'h10, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: inst0=%h pc=%h req=%b, want 10/10/0",
                         i, inst1, pc1, req1);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req1 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_req: req=%b, want 1", req1);
        end
        @(negedge clk);
        checks++;
        if ({inst1, pc1} !== {32'h14, 32'h14}) begin
            errors++;
            $display("FAIL stall_resume0: inst0=%h pc=%h, want 14/14", inst1, pc1);
        end
        @(negedge clk);
        checks++;
        if ({inst1, pc1} !== {32'h18, 32'h18}) begin
            errors++;
            $display("FAIL stall_resume1: inst0=%h pc=%h, want 18/18", inst1, pc1);
        end
    endtask

    task automatic test_branch_full;
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (req1 !== 1'b0) begin
            errors++;
            $display("FAIL br_full_req: req=%b, want 0", req1);
        end
        br_taken = 1'b1; br_target = 32'h103; stall = 1'b0;
        #1;
        checks++;
        if (req1 !== 1'b0) begin
            errors++;
            $display("FAIL br_req_gated: req=%b, want 0", req1);
        end
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        checks++;
        if ({inst1, valid1, pc1, addr1, req1} !== {32'h0, 1'b0, 32'h100, 32'h100, 1'b1}) begin
            errors++;
            $display("FAIL br_flush: inst0=%h valid=%b pc=%h addr=%h req=%b, want 0/0/100/100/1",
                     inst1, valid1, pc1, addr1, req1);
        end
        @(negedge clk);
        checks++;
        if ({inst1, pc1, valid1} !== {32'h100, 32'h100, 1'b1}) begin
            errors++;
            $display("FAIL br_target: inst0=%h pc=%h valid=%b, want 100/100/1", inst1, pc1, valid1);
        end
        @(negedge clk);
    endtask

    task automatic test_branch_stall;
        checks++;
        if (inst1 !== 32'h104) begin
            errors++;
            $display("FAIL brst_pre: inst0=%h, want 104", inst1);
        end
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h200;
        @(negedge clk);
        br_taken = 1'b0;
        checks++;
        if ({inst1, pc1, valid1} !== {32'h0, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL brst_flush: inst0=%h pc=%h valid=%b, want 0/200/0", inst1, pc1, valid1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({inst1, pc1, valid1} !== {32'h200, 32'h200, 1'b1}) begin
                errors++;
                $display("FAIL brst_target[%0d]: inst0=%h pc=%h valid=%b, want 200/200/1",
                         i, inst1, pc1, valid1);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_sparse_ack;
        logic [31:0] exp_pc;
        int nvalid;
        int nbub;
        ack_all = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        @(negedge clk);
        br_taken = 1'b0;
        exp_pc = 32'h300; nvalid = 0; nbub = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid1) begin
                checks++;
                if ({inst1, pc1} !== {exp_pc, exp_pc}) begin
                    errors++;
                    $display("FAIL sparse_word[%0d]: inst0=%h pc=%h, want %h/%h",
                             i, inst1, pc1, exp_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                nvalid++;
            end else begin
                checks++;
                if (inst1 !== 32'h0) begin
                    errors++;
                    $display("FAIL sparse_bubble[%0d]: inst0=%h, want 0", i, inst1);
                end
                nbub++;
            end
            @(negedge clk);
        end
        checks++;
        if (nvalid < 4 || nvalid > 6 || nbub < 8) begin
            errors++;
            $display("FAIL sparse_mix: valid=%0d bubbles=%0d, want 4..6 valid and >=8 bubbles",
                     nvalid, nbub);
        end
    endtask

    task automatic test_async_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({inst2, pc2, valid2, pc1} !== {32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_rst: inst0=%h pc=%h valid=%b pc_lo=%h, want 0/fffffff8/0/0",
                     inst2, pc2, valid2, pc1);
        end
        @(negedge clk);
        ack_all = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req2, addr2, inst2} !== {1'b1, 32'hFFFF_FFF8, 32'h0}) begin
            errors++;
            $display("FAIL wrap0: req=%b addr=%h inst0=%h, want 1/fffffff8/0", req2, addr2, inst2);
        end
        @(negedge clk);
        checks++;
        if ({addr2, inst2, pc2} !== {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8}) begin
            errors++;
            $display("FAIL wrap1: addr=%h inst0=%h pc=%h, want fffffffc/fffffff8/fffffff8",
                     addr2, inst2, pc2);
        end
        @(negedge clk);
        checks++;
        if ({addr2, inst2} !== {32'h0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap2: addr=%h inst0=%h, want 0/fffffffc", addr2, inst2);
        end
        @(negedge clk);
        checks++;
        if ({inst2, pc2, valid2} !== {32'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL wrap3: inst0=%h pc=%h valid=%b, want 0/0/1", inst2, pc2, valid2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_full();
        test_branch_stall();
        test_sparse_ack();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
